// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-select
// codes, stall FSM state encoding and the default register index width.
package pipe_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_unit.sv
// Purely combinational operand forwarding for EX and the WB-to-ID register
// file bypass. x0 is never forwarded; the younger MEM result wins over WB.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_byp_a,
  output logic                  id_byp_b
);

  logic mem_live;
  logic wb_live;

  assign mem_live = mem_regwrite && (mem_rd != '0);
  assign wb_live  = wb_regwrite && (wb_rd != '0);

  // Pick the youngest in-flight producer of each EX source operand.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_live && (mem_rd == ex_rs1))     fwd_a = FWD_MEM;
    else if (wb_live && (wb_rd == ex_rs1))  fwd_a = FWD_WB;
    if (mem_live && (mem_rd == ex_rs2))     fwd_b = FWD_MEM;
    else if (wb_live && (wb_rd == ex_rs2))  fwd_b = FWD_WB;
  end

  assign id_byp_a = wb_live && (wb_rd == id_rs1) && id_use_rs1;
  assign id_byp_b = wb_live && (wb_rd == id_rs2) && id_use_rs2;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage pipeline: forwarding/bypass selects,
// load-use stall FSM sized to data-memory latency, taken-branch flushes and
// saturating stall/flush performance counters.
module pipeline_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEFAULT,
  parameter int MEM_LAT      = 1,
  parameter int BRANCH_STAGE = 0,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_byp_a,
  output logic                  id_byp_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // rem only has to hold MEM_LAT-1, the cycles left after the first stall.
  localparam int REM_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic             LATE_BRANCH = (BRANCH_STAGE == 1);

  state_t           state;
  logic [REM_W-1:0] rem;
  logic             hz;
  logic             stall;
  logic [1:0]       fwd_a_raw;
  logic [1:0]       fwd_b_raw;
  logic             byp_a_raw;
  logic             byp_b_raw;

  fwd_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd (
    .ex_rs1      (ex_rs1),
    .ex_rs2      (ex_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .mem_rd      (mem_rd),
    .mem_regwrite(mem_regwrite),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite),
    .fwd_a       (fwd_a_raw),
    .fwd_b       (fwd_b_raw),
    .id_byp_a    (byp_a_raw),
    .id_byp_b    (byp_b_raw)
  );

  // ex_regwrite is part of the ID_EX control bundle but a load always writes,
  // so only ex_memread qualifies the load-use check.
  assign hz = ex_memread && (ex_rd != '0) &&
              ((id_use_rs1 && (ex_rd == id_rs1)) ||
               (id_use_rs2 && (ex_rd == id_rs2)));

  assign stall = ((state == RUN) && hz) || (state == STALL);

  // Pipeline control: reset forces a neutral pipeline, branch beats stall.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;
    id_byp_a     = 1'b0;
    id_byp_b     = 1'b0;
    if (!reset) begin
      fwd_a    = fwd_a_raw;
      fwd_b    = fwd_b_raw;
      id_byp_a = byp_a_raw;
      id_byp_b = byp_b_raw;
      if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = LATE_BRANCH;
      end else if (stall) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Stall FSM: first stall cycle is spent in RUN, the rest counted down in STALL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      rem   <= '0;
    end else if (branch_taken) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hz && (MEM_LAT > 1)) begin
            state <= STALL;
            rem   <= REM_INIT;
          end
        end
        STALL: begin
          if (rem == REM_W'(1)) begin
            state <= RUN;
            rem   <= '0;
          end else begin
            rem <= rem - REM_W'(1);
          end
        end
        default: begin
          state <= RUN;
          rem   <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters; a flushed stall cycle counts as a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !branch_taken && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
      if (branch_taken && (flush_cnt != CNT_MAX))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Randomised scoreboard bench for pipeline_hazard_unit. Two instances run in
// lockstep on the same inputs: a single-cycle-memory / EX-resolve build and a
// 3-cycle-memory / MEM-resolve build with 4-bit counters.
module tb_pipeline_hazard_unit;

  typedef struct {
    logic       reset;
    logic [4:0] id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic [4:0] ex_rd, ex_rs1, ex_rs2;
    logic       ex_regwrite, ex_memread;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
    logic       branch_taken;
  } stim_t;

  typedef struct {
    logic        pc_write, if_id_write;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        id_byp_a, id_byp_b;
    logic [31:0] stall_cnt, flush_cnt;
  } out_t;

  typedef struct {
    out_t l1;
    out_t l3;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
  logic       mem_regwrite, wb_regwrite, branch_taken;

  logic        l1_pc_write, l1_if_id_write, l1_if_id_flush, l1_id_ex_flush, l1_ex_mem_flush;
  logic [1:0]  l1_fwd_a, l1_fwd_b;
  logic        l1_id_byp_a, l1_id_byp_b;
  logic [31:0] l1_stall_cnt, l1_flush_cnt;
  logic        l3_pc_write, l3_if_id_write, l3_if_id_flush, l3_id_ex_flush, l3_ex_mem_flush;
  logic [1:0]  l3_fwd_a, l3_fwd_b;
  logic        l3_id_byp_a, l3_id_byp_b;
  logic [3:0]  l3_stall_cnt, l3_flush_cnt;

  exp_t sbq[$];
  int   vecCount = 0;
  int   errCount = 0;

  // Reference state: stall cycles still owed after the current one, and counts.
  int          owed[2];
  logic [31:0] stallCnt[2];
  logic [31:0] flushCnt[2];
  int          memLat[2]   = '{1, 3};
  int          brStage[2]  = '{0, 1};
  logic [31:0] cntMax[2]   = '{32'hFFFF_FFFF, 32'd15};

  always #5 clk = ~clk;

  pipeline_hazard_unit #(
    .REG_ADDR_W(5), .MEM_LAT(1), .BRANCH_STAGE(0), .CNT_W(32)
  ) dut_l1 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .pc_write(l1_pc_write), .if_id_write(l1_if_id_write),
    .if_id_flush(l1_if_id_flush), .id_ex_flush(l1_id_ex_flush), .ex_mem_flush(l1_ex_mem_flush),
    .fwd_a(l1_fwd_a), .fwd_b(l1_fwd_b), .id_byp_a(l1_id_byp_a), .id_byp_b(l1_id_byp_b),
    .stall_cnt(l1_stall_cnt), .flush_cnt(l1_flush_cnt)
  );

  pipeline_hazard_unit #(
    .REG_ADDR_W(5), .MEM_LAT(3), .BRANCH_STAGE(1), .CNT_W(4)
  ) dut_l3 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .branch_taken(branch_taken),
    .pc_write(l3_pc_write), .if_id_write(l3_if_id_write),
    .if_id_flush(l3_if_id_flush), .id_ex_flush(l3_id_ex_flush), .ex_mem_flush(l3_ex_mem_flush),
    .fwd_a(l3_fwd_a), .fwd_b(l3_fwd_b), .id_byp_a(l3_id_byp_a), .id_byp_b(l3_id_byp_b),
    .stall_cnt(l3_stall_cnt), .flush_cnt(l3_flush_cnt)
  );

  function automatic logic [1:0] refFwd(input logic [4:0] src, input stim_t s);
    if (s.mem_regwrite && s.mem_rd != 0 && s.mem_rd == src) return 2'b10;
    if (s.wb_regwrite && s.wb_rd != 0 && s.wb_rd == src)    return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic refHazard(input stim_t s);
    return s.ex_memread && s.ex_rd != 0 &&
           ((s.id_use_rs1 && s.ex_rd == s.id_rs1) || (s.id_use_rs2 && s.ex_rd == s.id_rs2));
  endfunction

  function automatic out_t refOutputs(input int k, input stim_t s);
    out_t o;
    logic stallNow;
    stallNow      = (owed[k] > 0) || refHazard(s);
    o.stall_cnt   = stallCnt[k];
    o.flush_cnt   = flushCnt[k];
    o.pc_write    = 1'b1;
    o.if_id_write = 1'b1;
    o.if_id_flush = 1'b0;
    o.id_ex_flush = 1'b0;
    o.ex_mem_flush = 1'b0;
    o.fwd_a = 2'b00;
    o.fwd_b = 2'b00;
    o.id_byp_a = 1'b0;
    o.id_byp_b = 1'b0;
    if (!s.reset) begin
      o.fwd_a    = refFwd(s.ex_rs1, s);
      o.fwd_b    = refFwd(s.ex_rs2, s);
      o.id_byp_a = s.wb_regwrite && s.wb_rd != 0 && s.wb_rd == s.id_rs1 && s.id_use_rs1;
      o.id_byp_b = s.wb_regwrite && s.wb_rd != 0 && s.wb_rd == s.id_rs2 && s.id_use_rs2;
      if (s.branch_taken) begin
        o.if_id_flush  = 1'b1;
        o.id_ex_flush  = 1'b1;
        o.ex_mem_flush = (brStage[k] == 1);
      end else if (stallNow) begin
        o.pc_write    = 1'b0;
        o.if_id_write = 1'b0;
        o.id_ex_flush = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic refStep(input int k, input stim_t s);
    logic stallNow;
    stallNow = (owed[k] > 0) || refHazard(s);
    if (s.reset) begin
      owed[k] = 0;
      stallCnt[k] = 0;
      flushCnt[k] = 0;
    end else begin
      if (s.branch_taken) begin
        if (flushCnt[k] < cntMax[k]) flushCnt[k] = flushCnt[k] + 1;
      end else if (stallNow) begin
        if (stallCnt[k] < cntMax[k]) stallCnt[k] = stallCnt[k] + 1;
      end
      if (s.branch_taken)     owed[k] = 0;
      else if (owed[k] > 0)   owed[k] = owed[k] - 1;
      else if (refHazard(s))  owed[k] = memLat[k] - 1;
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = s.reset;
    id_rs1       = s.id_rs1;
    id_rs2       = s.id_rs2;
    id_use_rs1   = s.id_use_rs1;
    id_use_rs2   = s.id_use_rs2;
    ex_rd        = s.ex_rd;
    ex_rs1       = s.ex_rs1;
    ex_rs2       = s.ex_rs2;
    ex_regwrite  = s.ex_regwrite;
    ex_memread   = s.ex_memread;
    mem_rd       = s.mem_rd;
    mem_regwrite = s.mem_regwrite;
    wb_rd        = s.wb_rd;
    wb_regwrite  = s.wb_regwrite;
    branch_taken = s.branch_taken;
    e.l1 = refOutputs(0, s);
    e.l3 = refOutputs(1, s);
    sbq.push_back(e);
    refStep(0, s);
    refStep(1, s);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareSet(input string tag, input out_t a, input out_t e);
    checkOutput({tag, ".pc_write"},     32'(a.pc_write),     32'(e.pc_write));
    checkOutput({tag, ".if_id_write"},  32'(a.if_id_write),  32'(e.if_id_write));
    checkOutput({tag, ".if_id_flush"},  32'(a.if_id_flush),  32'(e.if_id_flush));
    checkOutput({tag, ".id_ex_flush"},  32'(a.id_ex_flush),  32'(e.id_ex_flush));
    checkOutput({tag, ".ex_mem_flush"}, 32'(a.ex_mem_flush), 32'(e.ex_mem_flush));
    checkOutput({tag, ".fwd_a"},        32'(a.fwd_a),        32'(e.fwd_a));
    checkOutput({tag, ".fwd_b"},        32'(a.fwd_b),        32'(e.fwd_b));
    checkOutput({tag, ".id_byp_a"},     32'(a.id_byp_a),     32'(e.id_byp_a));
    checkOutput({tag, ".id_byp_b"},     32'(a.id_byp_b),     32'(e.id_byp_b));
    checkOutput({tag, ".stall_cnt"},    a.stall_cnt,         e.stall_cnt);
    checkOutput({tag, ".flush_cnt"},    a.flush_cnt,         e.flush_cnt);
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per falling edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      out_t a1, a3;
      e = sbq.pop_front();
      a1 = '{l1_pc_write, l1_if_id_write, l1_if_id_flush, l1_id_ex_flush, l1_ex_mem_flush,
             l1_fwd_a, l1_fwd_b, l1_id_byp_a, l1_id_byp_b, l1_stall_cnt, l1_flush_cnt};
      a3 = '{l3_pc_write, l3_if_id_write, l3_if_id_flush, l3_id_ex_flush, l3_ex_mem_flush,
             l3_fwd_a, l3_fwd_b, l3_id_byp_a, l3_id_byp_b,
             {28'b0, l3_stall_cnt}, {28'b0, l3_flush_cnt}};
      compareSet("l1", a1, e.l1);
      compareSet("l3", a3, e.l3);
    end
  end

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t loadUseStim();
    stim_t s;
    s = idleStim();
    s.ex_memread  = 1'b1;
    s.ex_regwrite = 1'b1;
    s.ex_rd       = 5'd3;
    s.id_rs2      = 5'd3;
    s.id_use_rs2  = 1'b1;
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.reset        = ($urandom_range(0, 63) == 0);
    s.id_rs1       = 5'($urandom_range(0, 3));
    s.id_rs2       = 5'($urandom_range(0, 3));
    s.id_use_rs1   = 1'($urandom);
    s.id_use_rs2   = 1'($urandom);
    s.ex_rd        = 5'($urandom_range(0, 3));
    s.ex_rs1       = 5'($urandom_range(0, 3));
    s.ex_rs2       = 5'($urandom_range(0, 3));
    s.ex_regwrite  = 1'($urandom);
    s.ex_memread   = 1'($urandom);
    s.mem_rd       = 5'($urandom_range(0, 3));
    s.mem_regwrite = 1'($urandom);
    s.wb_rd        = 5'($urandom_range(0, 3));
    s.wb_regwrite  = 1'($urandom);
    s.branch_taken = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    int    waitCycles;
    reset = 1'b1;
    {id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_regwrite, ex_memread} = '0;
    {mem_regwrite, wb_regwrite, branch_taken} = '0;
    for (int k = 0; k < 2; k++) begin
      owed[k] = 0;
      stallCnt[k] = 0;
      flushCnt[k] = 0;
    end
    repeat (2) @(posedge clk);

    s = idleStim(); s.reset = 1'b1;
    applyStimulus(s);

    // Forwarding priority and x0 suppression.
    s = idleStim();
    s.mem_rd = 5'd5; s.mem_regwrite = 1'b1; s.wb_rd = 5'd5; s.wb_regwrite = 1'b1; s.ex_rs1 = 5'd5;
    applyStimulus(s);
    s.mem_regwrite = 1'b0;
    applyStimulus(s);
    s.mem_regwrite = 1'b1; s.mem_rd = 5'd0; s.ex_rs1 = 5'd0;
    applyStimulus(s);

    // Load-use stall followed by ID_EX bubble cycles.
    applyStimulus(loadUseStim());
    repeat (4) applyStimulus(idleStim());

    // Branch in the second stall cycle aborts the stall.
    s = idleStim(); s.reset = 1'b1;
    applyStimulus(s);
    applyStimulus(loadUseStim());
    s = idleStim(); s.branch_taken = 1'b1;
    applyStimulus(s);
    repeat (2) applyStimulus(idleStim());

    // Continuous hazard drives the 4-bit stall counter into saturation.
    repeat (20) applyStimulus(loadUseStim());

    // Reset in the middle of a stall.
    applyStimulus(idleStim());
    applyStimulus(loadUseStim());
    s = idleStim(); s.reset = 1'b1;
    applyStimulus(s);
    repeat (3) applyStimulus(idleStim());

    for (int n = 0; n < 2000; n++) applyStimulus(randStim());

    waitCycles = 0;
    while (sbq.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    if (sbq.size() > 0) begin
      errCount++;
      $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Parametrised hazard controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Generates EX-stage forwarding selects and a WB-to-ID register-file bypass.
- Runs a stall FSM for load-use hazards; stall length follows data-memory read latency.
- Generates taken-branch flushes for a configurable resolve stage.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register index width
MEM_LAT, 1, data-memory read latency in cycles (>=1); equals load-use stall length
BRANCH_STAGE, 0, 0 = branch resolved in EX (2-slot flush); 1 = resolved in MEM (3-slot flush)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_rs1, id_rs2  in  REG_ADDR_W  source registers of instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
ex_rd  in  REG_ADDR_W  ID_EX destination
ex_regwrite, ex_memread  in  1  ID_EX control
ex_rs1, ex_rs2  in  REG_ADDR_W  ID_EX sources
mem_rd  in  REG_ADDR_W  EX_MEM destination
mem_regwrite  in  1  EX_MEM control
wb_rd  in  REG_ADDR_W  MEM_WB destination
wb_regwrite  in  1  MEM_WB control
branch_taken  in  1  taken branch/jump at resolve stage
pc_write  out  1  PC load enable
if_id_write  out  1  IF_ID load enable
if_id_flush, id_ex_flush, ex_mem_flush  out  1  zero control fields of that register next edge
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
id_byp_a, id_byp_b  out  1  select WB write data in place of regfile read in ID
stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Clock and reset: single clock, clk; reset synchronous active-high.
- While reset is high: state=RUN, rem=0, counters=0. Outputs are forced to pc_write=1, if_id_write=1, all flushes 0, fwd 00, byp 0.
- Forwarding (combinational):
  - fwd_a=10 if mem_regwrite && mem_rd!=0 && mem_rd==ex_rs1.
  - Otherwise fwd_a=01 if wb_regwrite && wb_rd!=0 && wb_rd==ex_rs1.
  - Otherwise fwd_a=00. fwd_b is the same using ex_rs2.
  - MEM has priority over WB. x0 is never forwarded.
- ID bypass: id_byp_a = wb_regwrite && wb_rd!=0 && wb_rd==id_rs1 && id_use_rs1; id_byp_b likewise for rs2.
- Load-use hazard: hz = ex_memread && ex_rd!=0 && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)).
- stall = (state==RUN && hz) || state==STALL.
  - While stall is asserted: pc_write=0, if_id_write=0, id_ex_flush=1 (bubble).
- FSM states: RUN, STALL (rem counts remaining stall cycles).
  - RUN & hz & MEM_LAT==1: one-cycle stall; remain in RUN.
  - RUN & hz & MEM_LAT>1: go to STALL with rem=MEM_LAT-1.
  - STALL: rem decrements each cycle. When rem==1, return to RUN next edge.
  - Total stall length is exactly MEM_LAT cycles.
- Branch flush (combinational on branch_taken):
  - Always asserts if_id_flush=1 and id_ex_flush=1.
  - Asserts ex_mem_flush=1 only when BRANCH_STAGE==1.
  - Forces pc_write=1 and if_id_write=1.
  - Branch has priority over stall. A branch during STALL aborts it: next state RUN, rem=0.
  - A branch coinciding with hz in RUN does not enter STALL.
- Counters (saturate at all-ones, no wrap):
  - stall_cnt increments each cycle stall is asserted and branch_taken is 0.
  - flush_cnt increments each cycle branch_taken is 1.
- Reset mid-stall: state returns to RUN immediately at that edge; no residual stall.
- Latency: all control outputs are combinational from inputs and state; the FSM and counters update at posedge clk.

Decomposition:
- Shared package pipe_pkg:
  - forwarding-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state encoding RUN/STALL;
  - REG_ADDR_W default.
- One sub-module, fwd_unit: the purely combinational forwarding/bypass compare, instantiated once.
- The FSM, flush logic and counters stay in the top.

Test Plan:
- EX-stage forwarding: mem_rd=5, mem_regwrite=1, wb_rd=5, wb_regwrite=1, ex_rs1=5 -> fwd_a=10. Clearing mem_regwrite -> fwd_a=01. Setting ex_rs1=0 with mem_rd=0 -> fwd_a=00.
- One-cycle load-use (MEM_LAT=1): ex_memread=1, ex_rd=3, id_rs2=3, id_use_rs2=1 -> exactly one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1.
- Multi-cycle load-use (MEM_LAT=3): same stimulus, with the ID_EX bubble presented after the first cycle -> stall held 3 consecutive cycles, then RUN; stall_cnt=3.
- Branch during STALL (MEM_LAT=3):
  - branch_taken=1 in 2nd stall cycle -> same cycle: if_id_flush=1, id_ex_flush=1, pc_write=1.
  - Next cycle: no stall.
  - Counters: flush_cnt=1, stall_cnt=1.
- BRANCH_STAGE=1 with branch_taken=1 -> ex_mem_flush=1; with BRANCH_STAGE=0 -> ex_mem_flush=0.
- Reset and saturation:
  - reset=1 during STALL -> next cycle state=RUN, counters=0.
  - CNT_W=4, 20 stall cycles -> stall_cnt holds 15.
